// File: rtl/chunk_serial_adder_if.sv
// Handshake and operand/result bundle for chunk_serial_adder.
// The master drives operands and out_ready; the slave returns in_ready and the result.
interface chunk_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out
    );
endinterface

// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + c_in, CHUNK bits per clock, carry held in a flop.
// Define CHUNK_SERIAL_ADDER_SUB_EN to honour the sub input (a - b, c_out = no-borrow).
module chunk_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic                clk,
    input  logic                rst,
    chunk_serial_adder_if.slave bus
);
    localparam int STEPS = WIDTH / CHUNK;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             c_out_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] cnt_q;

    logic [CHUNK:0]   chunk_sum_d;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] op_b_load_d;
    logic             carry_load_d;

`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    // Subtraction as a + ~b + 1; the final carry is then the no-borrow flag.
    assign op_b_load_d  = bus.sub ? ~bus.b : bus.b;
    assign carry_load_d = bus.sub ? 1'b1   : bus.c_in;
`else
    logic unused_sub;
    assign unused_sub   = bus.sub;
    assign op_b_load_d  = bus.b;
    assign carry_load_d = bus.c_in;
`endif

    always_comb begin
        chunk_sum_d = {1'b0, op_a_q[CHUNK-1:0]} + {1'b0, op_b_q[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, carry_q};
        // Result chunks enter at the MSB end so the LSB chunk lands at bit 0 after STEPS shifts.
        acc_d = (acc_q >> CHUNK) | (WIDTH'(chunk_sum_d[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_a_q  <= bus.a;
                        op_b_q  <= op_b_load_d;
                        carry_q <= carry_load_d;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    op_a_q  <= op_a_q >> CHUNK;
                    op_b_q  <= op_b_q >> CHUNK;
                    carry_q <= chunk_sum_d[CHUNK];
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(STEPS - 1)) begin
                        sum_q       <= acc_d;
                        c_out_q     <= chunk_sum_d[CHUNK];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed bench for chunk_serial_adder: 8/2, 2/1 and 8/8 configurations side by side.
module tb_chunk_serial_adder;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    chunk_serial_adder_if #(.WIDTH(8)) bus0();
    chunk_serial_adder_if #(.WIDTH(2)) bus1();
    chunk_serial_adder_if #(.WIDTH(8)) bus2();

    chunk_serial_adder #(.WIDTH(8), .CHUNK(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    chunk_serial_adder #(.WIDTH(2), .CHUNK(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Runs one operation on dut0; starts and ends 1ns after a rising edge.
    task automatic op0(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic s, input int hold,
                       input logic [7:0] esum, input logic ecout);
        int n;
        check({tag, "_in_ready_idle"}, bus0.in_ready, 1);
        bus0.in_valid  = 1'b1;
        bus0.a         = a;
        bus0.b         = b;
        bus0.c_in      = cin;
        bus0.sub       = s;
        bus0.out_ready = (hold == 0);
        @(posedge clk); #1;
        // Scramble operands after accept; they must not reach the result.
        bus0.in_valid = 1'b0;
        bus0.a        = ~a;
        bus0.b        = ~b;
        bus0.c_in     = ~cin;
        bus0.sub      = ~s;
        n = 0;
        while (!bus0.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_sum"}, bus0.sum, esum);
        check({tag, "_c_out"}, bus0.c_out, ecout);
        check({tag, "_in_ready_done"}, bus0.in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, bus0.out_valid, 1);
            check({tag, "_hold_sum"}, {bus0.c_out, bus0.sum}, {ecout, esum});
            check({tag, "_hold_in_ready"}, bus0.in_ready, 0);
        end
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        check({tag, "_released"}, bus0.out_valid, 0);
        check({tag, "_in_ready_after"}, bus0.in_ready, 1);
        check({tag, "_sum_held"}, {bus0.c_out, bus0.sum}, {ecout, esum});
    endtask

    // {c_out, sum} for a = k[2:1], c_in = k[0], b = 1 on the 2-bit instance.
    logic [2:0] exp1 [8] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5};

    initial begin
        int n;
        int seen;
        logic [2:0] kv;
        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.c_in = 1'b0; bus0.sub = 1'b0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0; bus1.sub = 1'b0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.c_in = 1'b0; bus2.sub = 1'b0; bus2.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus0.in_ready, 1);
        check("rst_out_valid", bus0.out_valid, 0);
        check("rst_sum", bus0.sum, 0);
        check("rst_c_out", bus0.c_out, 0);
        rst = 1'b0;

        op0("ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0, 0, 8'h00, 1'b1);
        op0("backpressure", 8'h3C, 8'h5A, 1'b1, 1'b0, 3, 8'h97, 1'b0);
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
        op0("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 0, 8'hFE, 1'b0);
        op0("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1, 0, 8'h02, 1'b1);
        op0("sub_00_00", 8'h00, 8'h00, 1'b1, 1'b1, 0, 8'h00, 1'b1);
`else
        op0("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 0, 8'h0C, 1'b0);
        op0("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1, 0, 8'h0C, 1'b0);
        op0("sub_00_00", 8'h00, 8'h00, 1'b1, 1'b1, 0, 8'h01, 1'b0);
`endif
        op0("pre_rst", 8'h3C, 8'h5A, 1'b1, 1'b0, 0, 8'h97, 1'b0);

        // Abort an operation whose carry chain is live on the second RUN cycle.
        bus0.in_valid = 1'b1; bus0.a = 8'hFF; bus0.b = 8'hFF; bus0.c_in = 1'b1; bus0.sub = 1'b0;
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun_in_ready", bus0.in_ready, 1);
        check("midrun_out_valid", bus0.out_valid, 0);
        check("midrun_sum", bus0.sum, 0);
        check("midrun_c_out", bus0.c_out, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus0.out_valid) seen++;
        end
        check("midrun_no_pulse", seen, 0);
        bus0.out_ready = 1'b0;
        op0("post_rst", 8'h10, 8'h20, 1'b0, 1'b0, 0, 8'h30, 1'b0);

        // Every {a, c_in} with b = 1 on the 2-bit, 1-bit-chunk instance.
        for (int k = 0; k < 8; k++) begin
            kv = k[2:0];
            bus1.in_valid = 1'b1; bus1.a = kv[2:1]; bus1.b = 2'b01; bus1.c_in = kv[0];
            bus1.out_ready = 1'b1;
            @(posedge clk); #1;
            bus1.in_valid = 1'b0;
            n = 0;
            while (!bus1.out_valid && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            check($sformatf("w2_lat_%0d", k), n, 2);
            check($sformatf("w2_res_%0d", k), {bus1.c_out, bus1.sum}, exp1[k]);
            @(posedge clk); #1;
            check($sformatf("w2_in_ready_%0d", k), bus1.in_ready, 1);
        end

        // Whole word in a single chunk.
        bus2.in_valid = 1'b1; bus2.a = 8'h80; bus2.b = 8'h80; bus2.c_in = 1'b1; bus2.out_ready = 1'b0;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        n = 0;
        while (!bus2.out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("w8c8_lat", n, 1);
        check("w8c8_sum", bus2.sum, 8'h01);
        check("w8c8_c_out", bus2.c_out, 1);
        bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        bus2.out_ready = 1'b0;
        check("w8c8_in_ready", bus2.in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
